// File: rtl/sim_pkg.sv
// sim_pkg: shared FSM state encoding and halt-cause codes for sim_halt_dump.
package sim_pkg;

   typedef logic [2:0] state_t;

   // Dump FSM states
   localparam logic [2:0] ST_RUN  = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_OUT  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Halt reasons reported on halt_cause
   localparam logic [1:0] HC_NONE    = 2'd0;
   localparam logic [1:0] HC_PC      = 2'd1;
   localparam logic [1:0] HC_TOHOST  = 2'd2;
   localparam logic [1:0] HC_TIMEOUT = 2'd3;

   // Resolve simultaneous triggers: tohost beats PC match beats timeout.
   function automatic logic [1:0] pick_cause(input logic tohost_hit,
                                             input logic pc_hit,
                                             input logic wd_hit);
      logic [1:0] cause;
      cause = HC_NONE;
      if (tohost_hit)
         cause = HC_TOHOST;
      else if (pc_hit)
         cause = HC_PC;
      else if (wd_hit)
         cause = HC_TIMEOUT;
      return cause;
   endfunction

endpackage

// File: rtl/sim_watchdog.sv
// sim_watchdog: saturating cycle counter plus the timeout compare.
// The expiry compare is only built when WATCHDOG_EN is defined; otherwise
// expired is tied low and no compare logic exists.
module sim_watchdog
#(
   parameter int unsigned TIMEOUT_CYC = 400000000
) (
   input  logic        CLK,
   input  logic        RSTN,
`ifdef WATCHDOG_EN
   input  logic        in_run,
`endif
   output logic [31:0] cycle_count,
   output logic        expired
);

   // Free-running cycle counter that sticks at all-ones instead of wrapping
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         cycle_count <= '0;
      else if (cycle_count != 32'hFFFF_FFFF)
         cycle_count <= cycle_count + 32'd1;
   end

`ifdef WATCHDOG_EN
   // Expiry only matters while the program is still running
   assign expired = in_run && (cycle_count >= TIMEOUT_CYC);
`else
   assign expired = 1'b0;
`endif

endmodule

// File: rtl/sim_halt_dump.sv
// sim_halt_dump: detects end-of-test (PC match, tohost store, optional
// watchdog when WATCHDOG_EN is defined), then streams a window of data
// memory out word by word with each word byte-reversed.
module sim_halt_dump
#(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [ADDR_W-1:0] DUMP_BASE   = '0,
   parameter int unsigned       DUMP_WORDS  = 1024,
   parameter logic [ADDR_W-1:0] HALT_PC     = 'h64,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0010_0000,
   parameter int unsigned       TIMEOUT_CYC = 400000000
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic [ADDR_W-1:0] pc_if,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic [1:0]        halt_cause,
   output logic [DATA_W-1:0] tohost_val,
   output logic [31:0]       cycle_count,
   output logic              done
);
   import sim_pkg::*;

   localparam int unsigned       NB             = DATA_W / 8;
   localparam logic [ADDR_W-1:0] BYTES_PER_WORD = ADDR_W'(NB);
   localparam logic [ADDR_W-1:0] LAST_INDEX     = DUMP_BASE + ADDR_W'(DUMP_WORDS - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] index_reg;
   logic [DATA_W-1:0] swapped;
   logic              tohost_hit;
   logic              pc_hit;
   logic              wd_hit;
   logic              any_hit;
   logic              last_word;

   sim_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .CLK         (CLK),
      .RSTN        (RSTN),
`ifdef WATCHDOG_EN
      .in_run      (state_reg == ST_RUN),
`endif
      .cycle_count (cycle_count),
      .expired     (wd_hit)
   );

   assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR);
   assign pc_hit     = (pc_if == HALT_PC);
   assign any_hit    = tohost_hit || pc_hit || wd_hit;
   assign last_word  = (index_reg == LAST_INDEX);

   // Byte reversal of the memory word: byte gi of the output is byte NB-1-gi of the input
   for (genvar gi = 0; gi < NB; gi++) begin : g_swap
      assign swapped[8*gi +: 8] = mem_rd_data[DATA_W-8-8*gi +: 8];
   end

   // Strobes decode straight from the state register so reset clears them at once
   assign mem_rd_en   = (state_reg == ST_RD);
   assign mem_rd_addr = mem_rd_en ? index_reg : '0;
   assign dump_valid  = (state_reg == ST_OUT);
   assign done        = (state_reg == ST_DONE);

   // Next-state selection: RUN waits for a trigger, then RD -> CAP -> OUT per word
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:  if (any_hit) state_next = ST_RD;
         ST_RD:   state_next = ST_CAP;
         ST_CAP:  state_next = ST_OUT;
         ST_OUT:  if (dump_ready) state_next = last_word ? ST_DONE : ST_RD;
         ST_DONE: state_next = ST_DONE;
         default: state_next = ST_RUN;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         state_reg <= ST_RUN;
      else
         state_reg <= state_next;
   end

   // Word index advances only when a non-final word is accepted; wraps naturally
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         index_reg <= DUMP_BASE;
      else if (state_reg == ST_OUT && dump_ready && !last_word)
         index_reg <= index_reg + ADDR_W'(1);
   end

   // Halt cause and tohost value are latched once, on the trigger edge in RUN
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         halt_cause <= HC_NONE;
         tohost_val <= '0;
      end else if (state_reg == ST_RUN && any_hit) begin
         halt_cause <= pick_cause(tohost_hit, pc_hit, wd_hit);
         if (tohost_hit)
            tohost_val <= st_data;
      end
   end

   // Output holding register: loaded in CAP and held through any stall in OUT
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         dump_addr <= '0;
         dump_data <= '0;
      end else if (state_reg == ST_CAP) begin
         dump_addr <= index_reg * BYTES_PER_WORD;
         dump_data <= swapped;
      end
   end

endmodule

// File: tb/tb_sim_halt_dump.sv
// tb_sim_halt_dump: directed scenarios for sim_halt_dump with a behavioural
// model of halt detection and the expected dump stream. Scenario D adapts to
// whether WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_sim_halt_dump;

   localparam int unsigned NWORDS = 4;
   localparam int unsigned TMO    = 100;
   localparam logic [31:0] HPC    = 32'h0000_0064;
   localparam logic [31:0] TOHOST = 32'h0010_0000;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [31:0] pc_if;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        mem_rd_en;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data = 32'h0;
   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_addr;
   logic [31:0] dump_data;
   logic [1:0]  halt_cause;
   logic [31:0] tohost_val;
   logic [31:0] cycle_count;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   sim_halt_dump #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DUMP_BASE   (32'h0),
      .DUMP_WORDS  (NWORDS),
      .HALT_PC     (HPC),
      .TOHOST_ADDR (TOHOST),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .pc_if       (pc_if),
      .st_valid    (st_valid),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_addr   (dump_addr),
      .dump_data   (dump_data),
      .halt_cause  (halt_cause),
      .tohost_val  (tohost_val),
      .cycle_count (cycle_count),
      .done        (done)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] idx);
      return 32'h1122_3340 + idx;
   endfunction

   function automatic logic [31:0] rev_bytes(input logic [31:0] w);
      logic [31:0] r;
      r = {<<8{w}};
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Data memory: one-cycle read latency; poison value whenever no read was issued
   always @(posedge CLK)
      mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : 32'hBAD0_BAD0;

   // Behavioural model: halt decision and position within the expected dump
   logic [31:0] m_cyc;
   logic        m_halted;
   logic [1:0]  m_cause;
   logic [31:0] m_tohost;
   logic [31:0] m_idx;
   int          m_left;

   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         m_cyc    <= 32'h0;
         m_halted <= 1'b0;
         m_cause  <= 2'd0;
         m_tohost <= 32'h0;
         m_idx    <= 32'h0;
         m_left   <= 0;
      end else begin
         m_cyc <= (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 32'd1;
         if (!m_halted) begin
            if (st_valid && st_addr == TOHOST) begin
               m_halted <= 1'b1; m_cause <= 2'd2; m_tohost <= st_data;
               m_idx <= 32'h0; m_left <= NWORDS;
            end else if (pc_if == HPC) begin
               m_halted <= 1'b1; m_cause <= 2'd1;
               m_idx <= 32'h0; m_left <= NWORDS;
            end
`ifdef WATCHDOG_EN
            else if (m_cyc >= TMO) begin
               m_halted <= 1'b1; m_cause <= 2'd3;
               m_idx <= 32'h0; m_left <= NWORDS;
            end
`endif
         end else if (m_left > 0 && dump_valid && dump_ready) begin
            m_idx  <= m_idx + 32'd1;
            m_left <= m_left - 1;
         end
      end
   end

   // Per-cycle comparison of the DUT against the model
   always @(negedge CLK) begin
      if (RSTN) begin
         check("cycle_count", cycle_count, m_cyc);
         check("halt_cause", halt_cause, m_cause);
         check("tohost_val", tohost_val, m_tohost);
         check("done", done, m_halted && m_left == 0);
         if (!(m_halted && m_left > 0)) begin
            check("dump_valid_idle", dump_valid, 1'b0);
            check("mem_rd_en_idle", mem_rd_en, 1'b0);
         end
         if (dump_valid) begin
            check("dump_addr", dump_addr, m_idx * 32'd4);
            check("dump_data", dump_data, rev_bytes(mem_word(m_idx)));
         end
         if (mem_rd_en)
            check("mem_rd_addr", mem_rd_addr, m_idx);
      end
   end

   // Record every accepted dump word, one line per transaction
   logic [31:0] acc_addr[$];
   logic [31:0] acc_data[$];
   always @(posedge CLK) begin
      if (RSTN && dump_valid && dump_ready) begin
         acc_addr.push_back(dump_addr);
         acc_data.push_back(dump_data);
         $display("dump word %0d: addr=%08h data=%08h", acc_addr.size() - 1, dump_addr, dump_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_rd_en"},   mem_rd_en, 1'b0);
      check({tag, "_mem_rd_addr"}, mem_rd_addr, 32'h0);
      check({tag, "_dump_valid"},  dump_valid, 1'b0);
      check({tag, "_dump_addr"},   dump_addr, 32'h0);
      check({tag, "_dump_data"},   dump_data, 32'h0);
      check({tag, "_halt_cause"},  halt_cause, 2'd0);
      check({tag, "_tohost_val"},  tohost_val, 32'h0);
      check({tag, "_cycle_count"}, cycle_count, 32'h0);
      check({tag, "_done"},        done, 1'b0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge CLK);
      RSTN = 1'b0;
      #1 check_reset_outputs(tag);
      pc_if = 32'h0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
      tick(3);
      acc_addr.delete();
      acc_data.delete();
      RSTN = 1'b1;
   endtask

   task automatic wait_cyc(input logic [31:0] target);
      int g = 0;
      while (cycle_count != target && g < 2000) begin
         @(negedge CLK);
         g++;
      end
      check("reach_cycle", cycle_count, target);
   endtask

   task automatic wait_done(input int budget);
      int g = 0;
      while (!done && g < budget) begin
         @(negedge CLK);
         g++;
      end
      check("done_reached", done, 1'b1);
   endtask

   task automatic wait_word(input logic [31:0] addr, input int budget);
      int g = 0;
      while (!(dump_valid && dump_addr == addr) && g < budget) begin
         @(negedge CLK);
         g++;
      end
      check("word_presented", dump_valid && dump_addr == addr, 1'b1);
   endtask

   task automatic pc_trigger();
      pc_if = HPC;
      tick(1);
      pc_if = 32'h0;
   endtask

   task automatic check_full_dump(input string tag);
      check({tag, "_nwords"}, acc_addr.size(), NWORDS);
      if (acc_addr.size() == NWORDS) begin
         for (int i = 0; i < NWORDS; i++) begin
            check({tag, "_addr"}, acc_addr[i], 32'(i * 4));
            check({tag, "_data"}, acc_data[i], rev_bytes(mem_word(32'(i))));
         end
      end
   endtask

   initial begin
      logic [31:0] held_addr;
      logic [31:0] held_data;

      RSTN = 1'b0; pc_if = 32'h0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
      dump_ready = 1'b0;
      tick(2);
      check_reset_outputs("por");
      RSTN = 1'b1;

      // A: PC halt at cycle 50, consumer always ready
      dump_ready = 1'b1;
      wait_cyc(32'd50);
      pc_trigger();
      check("A_cause", halt_cause, 2'd1);
      wait_done(100);
      check("A_done_cycle", cycle_count, 32'd63);
      check("A_nwords", acc_addr.size(), 4);
      if (acc_addr.size() == 4) begin
         check("A_addr0", acc_addr[0], 32'd0);
         check("A_addr1", acc_addr[1], 32'd4);
         check("A_addr2", acc_addr[2], 32'd8);
         check("A_addr3", acc_addr[3], 32'd12);
         check("A_data0", acc_data[0], 32'h4033_2211);
         check("A_data3", acc_data[3], 32'h4333_2211);
      end
      // Triggers in DONE are ignored and DONE is terminal
      pc_if = HPC; st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h1234_5678;
      tick(1);
      pc_if = 32'h0; st_valid = 1'b0;
      tick(5);
      check("A_terminal_done", done, 1'b1);
      check("A_terminal_cause", halt_cause, 2'd1);
      check("A_terminal_tohost", tohost_val, 32'h0);
      check("A_terminal_rd_en", mem_rd_en, 1'b0);

      // B: tohost store coinciding with PC match, then backpressure on word 1
      apply_reset("rstB");
      dump_ready = 1'b1;
      wait_cyc(32'd10);
      pc_if = HPC; st_valid = 1'b1; st_addr = TOHOST; st_data = 32'hDEAD_BEEF;
      tick(1);
      pc_if = 32'h0; st_valid = 1'b0; st_data = 32'h0;
      check("B_cause", halt_cause, 2'd2);
      check("B_tohost", tohost_val, 32'hDEAD_BEEF);
      wait_word(32'd4, 20);
      dump_ready = 1'b0;
      held_addr = dump_addr;
      held_data = dump_data;
      check("B_held_data", held_data, 32'h4133_2211);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("B_stall_valid", dump_valid, 1'b1);
         check("B_stall_addr", dump_addr, held_addr);
         check("B_stall_data", dump_data, held_data);
      end
      dump_ready = 1'b1;
      wait_done(100);
      check_full_dump("B");

      // C: reset while word 2 is on the output, then a fresh dump from the base
      apply_reset("rstC0");
      dump_ready = 1'b1;
      wait_cyc(32'd15);
      pc_trigger();
      wait_word(32'd8, 30);
      dump_ready = 1'b0;
      tick(1);
      RSTN = 1'b0;
      #1 check_reset_outputs("C_midreset");
      check("C_words_before_reset", acc_addr.size(), 2);
      tick(3);
      acc_addr.delete();
      acc_data.delete();
      RSTN = 1'b1;
      tick(2);
      check("C_after_valid", dump_valid, 1'b0);
      check("C_after_cause", halt_cause, 2'd0);
      dump_ready = 1'b1;
      wait_cyc(32'd20);
      pc_trigger();
      wait_done(100);
      check("C_cause", halt_cause, 2'd1);
      check_full_dump("C");

      // D: no trigger at all
      apply_reset("rstD");
      dump_ready = 1'b1;
`ifdef WATCHDOG_EN
      begin
         int g = 0;
         while (halt_cause == 2'd0 && g < 300) begin
            @(negedge CLK);
            g++;
         end
      end
      check("D_wd_cause", halt_cause, 2'd3);
      check("D_wd_cycle", cycle_count, 32'd101);
      wait_done(100);
      check_full_dump("D");
`else
      tick(150);
      check("D_no_wd_cause", halt_cause, 2'd0);
      check("D_no_wd_done", done, 1'b0);
      check("D_no_wd_valid", dump_valid, 1'b0);
      check("D_no_wd_cycle", cycle_count, 32'd150);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sim_halt_dump.md
SIM_HALT_DUMP -- requirements
Module: sim_halt_dump

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK is the clock and RSTN is the reset, with RSTN asserting immediately and deasserting synchronously to CLK.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- ADDR_W, 32, PC and byte-address width.
- DATA_W, 32, memory word width; a multiple of 8.
- DUMP_BASE, 0, first word index dumped.
- DUMP_WORDS, 1024, number of words dumped; at least 1.
- HALT_PC, 32'h64, fetch PC that ends the test.
- TOHOST_ADDR, 32'h0010_0000, store byte address that ends the test.
- TIMEOUT_CYC, 400000000, watchdog limit in cycles.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RSTN, in, 1, asynchronous active-low reset.
- pc_if, in, ADDR_W, fetch-stage PC.
- st_valid, in, 1, store retiring this cycle.
- st_addr, in, ADDR_W, store byte address.
- st_data, in, DATA_W, store data.
- mem_rd_en, out, 1, data-memory read strobe.
- mem_rd_addr, out, ADDR_W, word index to read.
- mem_rd_data, in, DATA_W, read data, valid one cycle after the strobe.
- dump_valid, out, 1, dump word available.
- dump_ready, in, 1, consumer accepts the dump word.
- dump_addr, out, ADDR_W, byte address of the dump word, equal to word index times DATA_W/8.
- dump_data, out, DATA_W, dump word with its byte order reversed.
- halt_cause, out, 2, halt reason: 0 none, 1 PC match, 2 tohost store, 3 timeout.
- tohost_val, out, DATA_W, data of the tohost store.
- cycle_count, out, 32, cycles since reset; saturates at all-ones.
- done, out, 1, dump complete.

Function
REQ-004 The FSM SHALL have exactly five states: RUN, RD, CAP, OUT and DONE.
REQ-005 In RUN, a halt trigger SHALL move the FSM to RD on the next edge and latch halt_cause.
- Triggers: pc_if==HALT_PC; st_valid with st_addr==TOHOST_ADDR; watchdog expiry.
- Simultaneous triggers SHALL be resolved with priority tohost > PC > timeout.
REQ-006 A tohost trigger SHALL latch st_data into tohost_val in the same edge that latches halt_cause.
REQ-007 Triggers outside RUN SHALL be ignored; halt_cause and tohost_val SHALL stay frozen until reset.
REQ-008 In RD, the block SHALL assert mem_rd_en for exactly one cycle with mem_rd_addr equal to the current index, then move to CAP.
REQ-009 In CAP, the block SHALL register mem_rd_data into the output holding register, then move to OUT.
REQ-010 In OUT, dump_valid SHALL be 1 and dump_addr/dump_data SHALL hold stable until dump_ready is sampled high.
- On acceptance of a non-final word: index increments and the FSM moves to RD.
- On acceptance of the final word (index == DUMP_BASE+DUMP_WORDS-1): the FSM moves to DONE.
REQ-011 The minimum dump throughput SHALL be one word per 3 cycles; dump_ready held low SHALL stall indefinitely without data loss.
REQ-012 DONE SHALL be terminal until reset, with done=1, dump_valid=0 and mem_rd_en=0.
REQ-013 The word index SHALL be ADDR_W bits wide and wrap modulo 2^ADDR_W without error.
REQ-014 cycle_count SHALL increment every cycle in every state and saturate at 32'hFFFF_FFFF.

Reset
REQ-015 While RSTN=0, the block SHALL force state=RUN, index=DUMP_BASE and all of the following outputs to 0: mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data, halt_cause, tohost_val, cycle_count, done.
REQ-016 Reset asserted mid-dump SHALL abort the dump immediately, with no partial word presented afterwards.

Configuration
REQ-017 With WATCHDOG_EN defined, the watchdog SHALL assert expiry when cycle_count reaches TIMEOUT_CYC while in RUN.
REQ-018 Without WATCHDOG_EN, no watchdog logic SHALL exist and halt_cause=3 SHALL never occur.

Structure
REQ-019 A shared package sim_pkg SHALL hold the FSM state encoding and the halt_cause constants (HC_NONE, HC_PC, HC_TOHOST, HC_TIMEOUT).
REQ-020 The counter and expiry compare SHALL live in one sub-module, sim_watchdog; its expiry logic is compiled only under WATCHDOG_EN.

Verification
REQ-021 The bench SHALL cover these scenarios:
- PC halt: pc_if=32'h64 at cycle 50, dump_ready=1, DUMP_WORDS=4 → halt_cause=1; 4 words at dump_addr 0,4,8,12 with bytes reversed; done=1 after 12 cycles.
- Tohost: store 32'hDEADBEEF to 32'h0010_0000 in the same cycle as the PC match → halt_cause=2, tohost_val=32'hDEADBEEF.
- Backpressure: dump_ready low for 10 cycles while dump_valid=1 → dump_addr/dump_data unchanged; no word skipped or duplicated.
- Reset mid-dump: RSTN=0 during OUT of word 2 → all outputs 0; after release, state RUN, and a fresh halt restarts at DUMP_BASE.
- Watchdog: WATCHDOG_EN defined, TIMEOUT_CYC=100, no trigger → halt_cause=3 at cycle 100; without the macro → stays in RUN.
